div_cu: RTL and testbench
=========================

DIV_CU -- requirements
Module: div_cu

Interface
REQ-001 Parameter: N, default 6, quotient/divisor width; iteration count equals N.
REQ-002 clk  input  1  rising-edge clock; one clock for the whole block.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a division; sampled only in IDLE.
REQ-005 ASign  input  1  sign bit of partial remainder A[N] from the divider datapath.
REQ-006 ready  output  1  high in IDLE only.
REQ-007 done  output  1  single-cycle pulse; Q/R in datapath valid.
REQ-008 ldAslc  output  1  A-mux select: 0 = dividend high half, 1 = adder Sum.
REQ-009 ldBslc  output  1  B-mux select: 0 = dividend low half, 1 = {B[N-1:1],Res}.
REQ-010 ldAen, ldBen, ldCen  output  1 each  parallel-load enables for A, B, C.
REQ-011 Shiften  output  1  shift A:B left by one, with all ld*en low.
REQ-012 Signslc  output  1  1 = subtract divisor (complement, carry-in 1), 0 = add.
REQ-013 Adden  output  1  adder capture enable; Sum is valid the following cycle.
REQ-014 Res  output  1  quotient bit written into B[0].

Function
REQ-015 All control outputs SHALL be decoded as Moore outputs from the state register (plus the registered quotient-bit flag); none are combinational from inputs.
REQ-016 Every control output not listed for a state SHALL be 0.
REQ-017 IDLE: ready=1; on start=1, go to LOAD; otherwise stay.
REQ-018 LOAD: ldAen=ldBen=ldCen=1, ldAslc=0, ldBslc=0; iteration counter cleared to 0; go to SHIFT.
REQ-019 SHIFT: Shiften=1; go to SUB.
REQ-020 SUB: Signslc=1, Adden=1; go to SUBWB.
REQ-021 SUBWB: Signslc=1, ldAslc=1, ldAen=1; go to CHECK.
REQ-022 CHECK: sample ASign; if 1, clear qbit and go to RESTORE; if 0, set qbit and go to SETQ.
REQ-023 RESTORE: Signslc=0, Adden=1; go to RESTWB.
REQ-024 RESTWB: Signslc=0, ldAslc=1, ldAen=1; go to SETQ.
REQ-025 SETQ: ldBslc=1, ldBen=1, Res=qbit; if counter == N-1, go to DONE; else increment counter and go to SHIFT.
REQ-026 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-027 Iteration latency: 5 cycles without restore, 7 cycles with restore.
REQ-028 Total latency from the start-sampled edge to the done cycle: 1 + Σ(iteration cycles) + 1.
REQ-029 start asserted outside IDLE SHALL be ignored (no queuing).
REQ-030 start held high through DONE SHALL begin a new division only after returning to IDLE (one IDLE cycle minimum).
REQ-031 The counter SHALL be ceil(log2 N) bits wide and SHALL never wrap during an operation.
REQ-032 ASign SHALL be ignored in all states except CHECK.
REQ-033 done and ready SHALL never be high together.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, counter=0, qbit=0, all control outputs 0, done=0, ready=1, regardless of state (including mid-iteration).
REQ-035 After rst deasserts, the first start SHALL be accepted on the first rising edge in IDLE.

Verification
REQ-036 N=6, ASign tied 0, start pulse: done 32 cycles after the start edge; Res=1 in all 6 SETQ cycles.
REQ-037 N=6, ASign tied 1: done 44 cycles after start; 6 RESTORE visits; Res=0 in every SETQ cycle.
REQ-038 With the divider datapath, Dividend=100, Divisor=7: done pulse, then Q=14, R=2, ASign=0.
REQ-039 Assert rst=0 in the 3rd iteration's SUB cycle: outputs 0 and ready=1 asynchronously; a new start then completes normally.
REQ-040 start pulsed during SHIFT and during DONE: no effect on sequence, no extra done pulse.
REQ-041 Assertion check throughout: at most one of {Shiften, ldAen} is high per cycle, except in LOAD where ldAen, ldBen and ldCen are all high.

Source files
------------

// File: rtl/div_cu.sv
// -----------------------------------------------------------------------------
// div_cu -- control unit for an N-bit restoring divider.
//
// Sequences the external A/B/C/adder datapath through one LOAD, N quotient
// iterations (SHIFT, SUB, SUBWB, CHECK, optional RESTORE/RESTWB, SETQ) and a
// one-cycle DONE pulse. All control outputs come straight from flops: the
// output word is decoded from the next state and registered, so the outputs
// are a pure function of the current state (and the quotient-bit flag).
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (forces IDLE, ready=1, rest 0)
//   start    begin a division; looked at only in IDLE
//   ASign    sign of partial remainder A[N]; looked at only in CHECK
//   ready    high in IDLE only
//   done     one-cycle pulse when Q/R in the datapath are valid
//   ldAslc   A-mux select: 0 = dividend high half, 1 = adder Sum
//   ldBslc   B-mux select: 0 = dividend low half, 1 = {B[N-1:1],Res}
//   ldAen    parallel-load enable for A
//   ldBen    parallel-load enable for B
//   ldCen    parallel-load enable for C (divisor)
//   Shiften  shift A:B left by one
//   Signslc  1 = subtract divisor, 0 = add divisor
//   Adden    adder capture enable (Sum valid the following cycle)
//   Res      quotient bit written into B[0]
// -----------------------------------------------------------------------------
module div_cu #(
    parameter int N = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ASign,
    output logic ready,
    output logic done,
    output logic ldAslc,
    output logic ldBslc,
    output logic ldAen,
    output logic ldBen,
    output logic ldCen,
    output logic Shiften,
    output logic Signslc,
    output logic Adden,
    output logic Res
);

    // Counter only has to reach N-1, so it never wraps during an operation.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_SHIFT   = 4'd2,
        S_SUB     = 4'd3,
        S_SUBWB   = 4'd4,
        S_CHECK   = 4'd5,
        S_RESTORE = 4'd6,
        S_RESTWB  = 4'd7,
        S_SETQ    = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    // Output word layout:
    // [10] ready [9] done [8] ldAslc [7] ldBslc [6] ldAen [5] ldBen
    // [4] ldCen [3] Shiften [2] Signslc [1] Adden [0] Res
    localparam logic [10:0] OUT_IDLE    = 11'h400;
    localparam logic [10:0] OUT_LOAD    = 11'h070;
    localparam logic [10:0] OUT_SHIFT   = 11'h008;
    localparam logic [10:0] OUT_SUB     = 11'h006;
    localparam logic [10:0] OUT_SUBWB   = 11'h144;
    localparam logic [10:0] OUT_RESTORE = 11'h002;
    localparam logic [10:0] OUT_RESTWB  = 11'h140;
    localparam logic [10:0] OUT_SETQ    = 11'h0A0;
    localparam logic [10:0] OUT_DONE    = 11'h200;
    localparam logic [10:0] OUT_NONE    = 11'h000;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            qbit_q;
    logic            qbit_d;
    logic [10:0]     out_q;
    logic [10:0]     out_d;

    // Next-state, iteration counter and quotient-bit logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qbit_d  = qbit_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                state_d = S_SUB;
            end
            S_SUB: begin
                state_d = S_SUBWB;
            end
            S_SUBWB: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Negative trial remainder: quotient bit 0 and undo the subtract.
                if (ASign) begin
                    qbit_d  = 1'b0;
                    state_d = S_RESTORE;
                end else begin
                    qbit_d  = 1'b1;
                    state_d = S_SETQ;
                end
            end
            S_RESTORE: begin
                state_d = S_RESTWB;
            end
            S_RESTWB: begin
                state_d = S_SETQ;
            end
            S_SETQ: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode the control word for the state being entered, so it can be registered.
    always_comb begin
        out_d = OUT_NONE;
        case (state_d)
            S_IDLE:    out_d = OUT_IDLE;
            S_LOAD:    out_d = OUT_LOAD;
            S_SHIFT:   out_d = OUT_SHIFT;
            S_SUB:     out_d = OUT_SUB;
            S_SUBWB:   out_d = OUT_SUBWB;
            S_CHECK:   out_d = OUT_NONE;
            S_RESTORE: out_d = OUT_RESTORE;
            S_RESTWB:  out_d = OUT_RESTWB;
            S_SETQ:    out_d = OUT_SETQ | {10'b00_0000_0000, qbit_d};
            S_DONE:    out_d = OUT_DONE;
            default:   out_d = OUT_IDLE;
        endcase
    end

    // State, counter, quotient flag and registered control word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            qbit_q  <= 1'b0;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qbit_q  <= qbit_d;
            out_q   <= out_d;
        end
    end

    assign ready   = out_q[10];
    assign done    = out_q[9];
    assign ldAslc  = out_q[8];
    assign ldBslc  = out_q[7];
    assign ldAen   = out_q[6];
    assign ldBen   = out_q[5];
    assign ldCen   = out_q[4];
    assign Shiften = out_q[3];
    assign Signslc = out_q[2];
    assign Adden   = out_q[1];
    assign Res     = out_q[0];

endmodule

// File: tb/tb_div_cu.sv
// -----------------------------------------------------------------------------
// tb_div_cu -- self-checking bench for div_cu (N = 6).
// The reference is a cycle timeline built from the per-state control table
// and a list of per-iteration sign decisions; a small behavioural restoring
// datapath is attached for end-to-end quotient/remainder checks.
// -----------------------------------------------------------------------------
module tb_div_cu;
    localparam int N = 6;

    // Expected control words, bit order:
    // ready done ldAslc ldBslc ldAen ldBen ldCen Shiften Signslc Adden Res
    localparam logic [10:0] V_IDLE    = 11'b10_000_000_000;
    localparam logic [10:0] V_LOAD    = 11'b00_001_110_000;
    localparam logic [10:0] V_SHIFT   = 11'b00_000_001_000;
    localparam logic [10:0] V_SUB     = 11'b00_000_000_110;
    localparam logic [10:0] V_SUBWB   = 11'b00_101_000_100;
    localparam logic [10:0] V_CHECK   = 11'b00_000_000_000;
    localparam logic [10:0] V_RESTORE = 11'b00_000_000_010;
    localparam logic [10:0] V_RESTWB  = 11'b00_101_000_000;
    localparam logic [10:0] V_SETQ    = 11'b00_010_100_000;
    localparam logic [10:0] V_DONE    = 11'b01_000_000_000;

    localparam int T_NONE = 0, T_SHIFT = 1, T_CHECK = 2, T_DONE = 3, T_SUB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic asign_tb = 1'b0;
    logic use_dp = 1'b0;
    logic asign_w;
    logic ready, done, ldAslc, ldBslc, ldAen, ldBen, ldCen, Shiften, Signslc, Adden, Res;
    logic [10:0] obs;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [10:0] v;
        int          tag;
        bit          asv;
    } cyc_t;

    cyc_t exp_q[$];
    bit   plan[$];

    // Behavioural datapath
    logic [N:0]     dp_a, dp_s;
    logic [N-1:0]   dp_b, dp_c;
    logic [2*N-1:0] dvd = '0;
    logic [N-1:0]   dvs = '0;

    always #5 clk = ~clk;

    assign obs     = {ready, done, ldAslc, ldBslc, ldAen, ldBen, ldCen, Shiften, Signslc, Adden, Res};
    assign asign_w = use_dp ? dp_a[N] : asign_tb;

    div_cu #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .ASign(asign_w),
        .ready(ready), .done(done), .ldAslc(ldAslc), .ldBslc(ldBslc),
        .ldAen(ldAen), .ldBen(ldBen), .ldCen(ldCen), .Shiften(Shiften),
        .Signslc(Signslc), .Adden(Adden), .Res(Res)
    );

    // Restoring divider datapath steered by the control outputs.
    always @(posedge clk) begin
        if (ldAen) dp_a <= ldAslc ? dp_s : {1'b0, dvd[2*N-1:N]};
        else if (Shiften) dp_a <= {dp_a[N-1:0], dp_b[N-1]};
        if (ldBen) dp_b <= ldBslc ? {dp_b[N-1:1], Res} : dvd[N-1:0];
        else if (Shiften) dp_b <= {dp_b[N-2:0], 1'b0};
        if (ldCen) dp_c <= dvs;
        if (Adden) dp_s <= Signslc ? dp_a - {1'b0, dp_c} : dp_a + {1'b0, dp_c};
    end

    task automatic push(input logic [10:0] v, input int tag, input bit asv);
        cyc_t c;
        c.v = v; c.tag = tag; c.asv = asv;
        exp_q.push_back(c);
    endtask

    // Expected cycle sequence from LOAD through DONE for the current plan.
    task automatic build_timeline();
        exp_q.delete();
        push(V_LOAD, T_NONE, 1'b0);
        foreach (plan[i]) begin
            push(V_SHIFT, T_SHIFT, 1'b0);
            push(V_SUB, T_SUB, 1'b0);
            push(V_SUBWB, T_NONE, 1'b0);
            push(V_CHECK, T_CHECK, plan[i]);
            if (plan[i]) begin
                push(V_RESTORE, T_NONE, 1'b0);
                push(V_RESTWB, T_NONE, 1'b0);
            end
            push(V_SETQ | {10'd0, ~plan[i]}, T_NONE, 1'b0);
        end
        push(V_DONE, T_DONE, 1'b0);
    endtask

    task automatic check_vec(input string name, input int cyc, input logic [10:0] want);
        checks++;
        if (obs !== want)
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, obs, want);
        else
            passed++;
    endtask

    // mode: 0 = ASign 0 every iteration, 1 = ASign 1, 2 = random.
    // Entered between edges with the DUT idle; returns at posedge+1.
    task automatic run_op(input string name, input int mode, input bit start_shift,
                          input bit start_done, input bit hold, input int abort_sub);
        int nrest = 0;
        int exp_lat, done_at, res_ones, subs;
        bit d;
        plan.delete();
        for (int i = 0; i < N; i++) begin
            d = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            plan.push_back(d);
            nrest += int'(d);
        end
        build_timeline();
        exp_lat  = 1 + (N - nrest) * 5 + nrest * 7 + 1;
        done_at  = 0;
        res_ones = 0;
        subs     = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check_vec(name, k + 1, exp_q[k].v);
            checks++;
            if ((done && ready) || (Shiften && ldAen))
                $display("FAIL %s_excl cyc=%0d: got done=%b ready=%b Shiften=%b ldAen=%b expected exclusive",
                         name, k + 1, done, ready, Shiften, ldAen);
            else
                passed++;
            if (done && done_at == 0) done_at = k + 1;
            if (Res) res_ones++;
            asign_tb = (exp_q[k].tag == T_CHECK) ? exp_q[k].asv : 1'($urandom_range(0, 1));
            start = (exp_q[k].tag == T_SHIFT && start_shift) ||
                    (exp_q[k].tag == T_DONE && (start_done || hold));
            if (exp_q[k].tag == T_SUB) begin
                subs++;
                if (abort_sub != 0 && subs == abort_sub) begin
                    start = 1'b0;
                    #2 rst = 1'b0;
                    #1 check_vec({name, "_async_rst"}, k + 1, V_IDLE);
                    @(posedge clk); #1;
                    check_vec({name, "_rst_hold"}, k + 2, V_IDLE);
                    #2 rst = 1'b1;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        if (!hold) start = 1'b0;
        checks++;
        if (done_at !== exp_lat)
            $display("FAIL %s_latency: got %0d expected %0d", name, done_at, exp_lat);
        else
            passed++;
        checks++;
        if (res_ones !== N - nrest)
            $display("FAIL %s_res_count: got %0d expected %0d", name, res_ones, N - nrest);
        else
            passed++;
        check_vec({name, "_idle"}, exp_q.size() + 1, V_IDLE);
        if (!hold) begin
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                check_vec({name, "_stay_idle"}, exp_q.size() + 2 + j, V_IDLE);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_vec("reset", 0, V_IDLE);
        start = 1'b1;
        @(posedge clk); #1;
        check_vec("reset_start_ignored", 0, V_IDLE);
        start = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_no_restore();
        run_op("no_restore", 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_all_restore();
        run_op("all_restore", 1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_op("random", 2, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_op("start_ignored", 2, 1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 2, 1'b0, 1'b0, 1'b1, 0);
        run_op("b2b_second", 2, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        run_op("reset_mid", 0, 1'b0, 1'b0, 1'b0, 3);
        run_op("after_reset", 2, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_datapath(input logic [2*N-1:0] a, input logic [N-1:0] b);
        bit got = 1'b0;
        logic [2*N-1:0] q_exp, r_exp;
        q_exp = a / {{N{1'b0}}, b};
        r_exp = a % {{N{1'b0}}, b};
        use_dp = 1'b1;
        dvd = a;
        dvs = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) $display("FAIL dp_timeout %0d/%0d: got no done expected done", a, b);
        else passed++;
        checks++;
        if ({{N{1'b0}}, dp_b} !== q_exp)
            $display("FAIL dp_quotient %0d/%0d: got %0d expected %0d", a, b, dp_b, q_exp);
        else passed++;
        checks++;
        if ({{(N-1){1'b0}}, dp_a} !== r_exp)
            $display("FAIL dp_remainder %0d/%0d: got %0d expected %0d", a, b, dp_a, r_exp);
        else passed++;
        checks++;
        if (asign_w !== 1'b0)
            $display("FAIL dp_asign %0d/%0d: got %b expected 0", a, b, asign_w);
        else passed++;
        @(posedge clk); #1;
        use_dp = 1'b0;
    endtask

    task automatic test_datapath_all();
        int b, a;
        test_datapath(12'd100, 6'd7);
        for (int i = 0; i < 4; i++) begin
            b = $urandom_range(1, 63);
            a = $urandom_range(0, b * 64 - 1);
            test_datapath(12'(a), 6'(b));
        end
    endtask

    initial begin
        test_reset();
        test_no_restore();
        test_all_restore();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_datapath_all();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
